// File: rtl/led_div_seq_pkg.sv
// Shared types and widths for the LED divider sequencer.
// The program table holds NSTEP entries of {divider, dwell-in-ticks}.
package led_pkg;

  localparam int DIV_W   = 5;
  localparam int DWELL_W = 16;
  localparam int NSTEP   = 4;
  localparam int STEP_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    HOST  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DIV_W-1:0]   div;
    logic [DWELL_W-1:0] dwell;
  } prog_entry_t;

  // A zero dwell still holds the rate for one tick.
  function automatic logic [DWELL_W-1:0] dwell_target(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/led_div_seq_tick_gen.sv
// Prescaler that counts 0..TICK_CYC-1 and emits a one-cycle tick on the
// last count; a synchronous clear holds it at zero.
module tick_gen #(
  parameter int TICK_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = at_last && !clr_i;

endmodule

// File: rtl/led_div_seq.sv
// Steps the LED counter divider through a 4-entry blink program with a
// per-entry dwell, and lets a host override pre-empt the program.
module led_div_seq
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               host_req_i,
  input  logic [DIV_W-1:0]   host_div_i,
  output logic               host_ack_o,
  input  logic               prog_we_i,
  input  logic [STEP_W-1:0]  prog_addr_i,
  input  logic [DIV_W-1:0]   prog_div_i,
  input  logic [DWELL_W-1:0] prog_dwell_i,
  output logic [DIV_W-1:0]   div_o,
  output logic               wren_o,
  output logic [STEP_W-1:0]  step_o,
  output logic               busy_o,
  output state_e             dbg_state_o
);

  localparam int TICK_CYC = CLK_HZ / TICK_HZ;

  if ((TICK_CYC < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_tick
    $error("led_div_seq: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  // wren_o is a one-cycle strobe with div_o valid in the same cycle; there
  // is no back-pressure, the LED counter must accept every strobe.
  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               wren_q, wren_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_tgt_q, dwell_tgt_d;
  logic               host_wr_q, host_wr_d;
  prog_entry_t        table_q [NSTEP];
  prog_entry_t        table_d [NSTEP];

  prog_entry_t        cur;
  logic               tick;
  logic               tick_clr;
  logic               expire;

  assign tick_clr = (state_q != DWELL);

  tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick_gen (
    .clk    (clk100),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // The tick that brings the count up to the target ends the dwell.
  assign expire = tick &&
                  (({1'b0, dwell_cnt_q} + 17'd1) >= {1'b0, dwell_tgt_q});

  always_comb begin
    table_d = table_q;
    if (prog_we_i) begin
      table_d[prog_addr_i].div   = prog_div_i;
      table_d[prog_addr_i].dwell = prog_dwell_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    div_d       = div_q;
    wren_d      = 1'b0;
    ack_d       = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    dwell_tgt_d = dwell_tgt_q;
    host_wr_d   = 1'b0;
    cur         = table_q[step_q];

    case (state_q)
      IDLE: begin
        if (host_req_i) begin
          state_d = HOST;
        end else if (en_i) begin
          state_d = LOAD;
          step_d  = '0;
        end
      end

      LOAD: begin
        if (!en_i) begin
          state_d = IDLE;
        end else begin
          div_d       = cur.div;
          wren_d      = 1'b1;
          dwell_cnt_d = '0;
          dwell_tgt_d = dwell_target(cur.dwell);
          state_d     = host_req_i ? HOST : DWELL;
        end
      end

      DWELL: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (host_req_i) begin
          state_d = HOST;
        end else if (expire) begin
          state_d = LOAD;
          step_d  = step_q + STEP_W'(1);
        end else if (tick) begin
          dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
      end

      HOST: begin
        // Only the first HOST cycle writes; later host_div_i changes are ignored.
        if (!host_wr_q) begin
          div_d  = host_div_i;
          wren_d = 1'b1;
          ack_d  = 1'b1;
        end
        if (host_req_i) begin
          host_wr_d = 1'b1;
        end else begin
          state_d = en_i ? LOAD : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      div_q       <= '0;
      wren_q      <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      dwell_cnt_q <= '0;
      dwell_tgt_q <= '0;
      host_wr_q   <= 1'b0;
      for (int i = 0; i < NSTEP; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      div_q       <= div_d;
      wren_q      <= wren_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_tgt_q <= dwell_tgt_d;
      host_wr_q   <= host_wr_d;
      table_q     <= table_d;
    end
  end

  assign div_o       = div_q;
  assign wren_o      = wren_q;
  assign host_ack_o  = ack_q;
  assign step_o      = step_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_led_div_seq.sv
// Directed bench for led_div_seq at TICK_CYC=10: expected writes are queued
// as {wren, div, step, ack, gap} and a negedge monitor checks each strobe.
module tb_led_div_seq;
  import led_pkg::*;

  localparam int W = 25;

  logic               clk100 = 1'b0;
  logic               rst_n  = 1'b1;
  logic               en_i;
  logic               host_req_i;
  logic [DIV_W-1:0]   host_div_i;
  logic               host_ack_o;
  logic               prog_we_i;
  logic [STEP_W-1:0]  prog_addr_i;
  logic [DIV_W-1:0]   prog_div_i;
  logic [DWELL_W-1:0] prog_dwell_i;
  logic [DIV_W-1:0]   div_o;
  logic               wren_o;
  logic [STEP_W-1:0]  step_o;
  logic               busy_o;
  state_e             dbg_state_o;

  logic [W-1:0] exp_q[$];
  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_wren = 0;
  int wr_idx    = 0;

  // ---------------- clock / reset ----------------
  always #5 clk100 = ~clk100;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  led_div_seq #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .en_i         (en_i),
    .host_req_i   (host_req_i),
    .host_div_i   (host_div_i),
    .host_ack_o   (host_ack_o),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_div_i   (prog_div_i),
    .prog_dwell_i (prog_dwell_i),
    .div_o        (div_o),
    .wren_o       (wren_o),
    .step_o       (step_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk100);
    #1;
  endtask

  task automatic prog_write(input int addr, input int div, input int dwell);
    prog_we_i    = 1'b1;
    prog_addr_i  = STEP_W'(addr);
    prog_div_i   = DIV_W'(div);
    prog_dwell_i = DWELL_W'(dwell);
    cycles(1);
    prog_we_i    = 1'b0;
  endtask

  // gap = cycles since the previous strobe; 0 means not checked
  function automatic logic [W-1:0] item(input int div, input int step, input bit ack,
                                        input int gap);
    return {1'b1, DIV_W'(div), STEP_W'(step), ack, 16'(gap)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      cycles(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected writes never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk100) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    int gap;
    cyc++;
    if (rst_n && (wren_o || host_ack_o)) begin
      gap = cyc - last_wren;
      last_wren = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wren=%0d div=%0d step=%0d ack=%0d, required no write",
                 wren_o, div_o, step_o, host_ack_o);
      end else begin
        exp_v = exp_q.pop_front();
        act_v = {wren_o, div_o, step_o, host_ack_o,
                 (exp_v[15:0] == 16'd0) ? 16'd0 : 16'(gap)};
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL write_%0d: got wren=%0d div=%0d step=%0d ack=%0d gap=%0d, required wren=%0d div=%0d step=%0d ack=%0d gap=%0d",
                   wr_idx, act_v[24], act_v[23:19], act_v[18:17], act_v[16], act_v[15:0],
                   exp_v[24], exp_v[23:19], exp_v[18:17], exp_v[16], exp_v[15:0]);
        end
        wr_idx++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int divs[4]   = '{3, 7, 12, 31};
    int dwells[4] = '{2, 1, 3, 0};

    en_i = 1'b0; host_req_i = 1'b0; host_div_i = '0;
    prog_we_i = 1'b0; prog_addr_i = '0; prog_div_i = '0; prog_dwell_i = '0;

    // reset and idle
    #1 rst_n = 1'b0;
    #1;
    chk("rst_div", 32'(div_o), 0);
    chk("rst_wren", 32'(wren_o), 0);
    chk("rst_ack", 32'(host_ack_o), 0);
    chk("rst_step", 32'(step_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_state", 32'(dbg_state_o), 32'(IDLE));
    cycles(3);
    rst_n = 1'b1;
    cycles(100);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_state", 32'(dbg_state_o), 32'(IDLE));
    chk("idle_div", 32'(div_o), 0);

    // full program cycle: spacing 21, 11, 31, 11 then into step 1 again
    for (int i = 0; i < 4; i++) prog_write(i, divs[i], dwells[i]);
    exp_q.push_back(item(3, 0, 0, 0));
    exp_q.push_back(item(7, 1, 0, 21));
    exp_q.push_back(item(12, 2, 0, 11));
    exp_q.push_back(item(31, 3, 0, 31));
    exp_q.push_back(item(3, 0, 0, 11));
    exp_q.push_back(item(7, 1, 0, 21));
    en_i = 1'b1;
    cycles(1);
    chk("load_no_wren_yet", 32'(wren_o), 0);
    chk("load_busy", 32'(busy_o), 1);
    cycles(1);
    chk("first_wren_latency", 32'(wren_o), 1);
    drain("program_cycle");
    chk("prog_step1", 32'(step_o), 1);

    // host override during step 1 dwell, held 50 cycles
    cycles(3);
    host_req_i = 1'b1;
    host_div_i = 5'd9;
    exp_q.push_back(item(9, 1, 1, 5));
    exp_q.push_back(item(7, 1, 0, 50));
    exp_q.push_back(item(12, 2, 0, 11));
    cycles(2);
    chk("host_ack_pulse", 32'(host_ack_o), 1);
    cycles(10);
    host_div_i = 5'd17;
    chk("host_state", 32'(dbg_state_o), 32'(HOST));
    cycles(38);
    chk("host_div_held", 32'(div_o), 9);
    host_req_i = 1'b0;
    drain("override");

    // rewrite the active entry; it only applies on the next visit
    cycles(2);
    prog_write(2, 20, 3);
    cycles(5);
    chk("live_div_hold", 32'(div_o), 12);
    chk("live_step", 32'(step_o), 2);
    exp_q.push_back(item(31, 3, 0, 31));
    exp_q.push_back(item(3, 0, 0, 11));
    exp_q.push_back(item(7, 1, 0, 21));
    exp_q.push_back(item(20, 2, 0, 11));
    drain("live_write");

    // disable mid-dwell, then re-enable from step 0
    cycles(5);
    en_i = 1'b0;
    cycles(1);
    chk("dis_busy", 32'(busy_o), 0);
    chk("dis_state", 32'(dbg_state_o), 32'(IDLE));
    chk("dis_div_hold", 32'(div_o), 20);
    cycles(40);
    chk("dis_div_still", 32'(div_o), 20);
    exp_q.push_back(item(3, 0, 0, 0));
    exp_q.push_back(item(7, 1, 0, 21));
    en_i = 1'b1;
    cycles(2);
    chk("reen_step0", 32'(step_o), 0);
    drain("reenable");

    // asynchronous reset mid-dwell clears outputs and table
    cycles(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_div", 32'(div_o), 0);
    chk("mid_rst_step", 32'(step_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_state", 32'(dbg_state_o), 32'(IDLE));
    exp_q.push_back(item(0, 0, 0, 0));
    exp_q.push_back(item(0, 1, 0, 11));
    cycles(1);
    rst_n = 1'b1;
    drain("reset_mid");

    // override request landing in LOAD: back-to-back program and host writes
    en_i = 1'b0;
    cycles(2);
    chk("lh_idle", 32'(dbg_state_o), 32'(IDLE));
    prog_write(0, 5, 1);
    exp_q.push_back(item(5, 0, 0, 0));
    exp_q.push_back(item(22, 0, 1, 1));
    exp_q.push_back(item(5, 0, 0, 10));
    en_i = 1'b1;
    cycles(1);
    host_req_i = 1'b1;
    host_div_i = 5'd22;
    cycles(10);
    host_req_i = 1'b0;
    drain("load_host");

    en_i = 1'b0;
    cycles(3);
    chk("final_busy", 32'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_div_seq.md
# led_div_seq

Sequences the divider input of the LED counter block through a 4-step blink program, holding each rate for a programmable dwell time. A host override request pre-empts the program. The block drives the counter's divider and write-enable pins and sits between the PS-side register interface and the LED counter instance.

## Interface
- CLK_HZ, 100_000_000: clk100 frequency in Hz.
- TICK_HZ, 1000: dwell tick rate. TICK_CYC = CLK_HZ/TICK_HZ must be ≥ 2 and an integer.
- clk100  in  1  system clock. The only clock in the block.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en_i  in  1  program run enable (level).
- host_req_i  in  1  host override request (level).
- host_div_i  in  5  divider value used during override.
- host_ack_o  out  1  one-cycle pulse when the override value is written.
- prog_we_i  in  1  program table write strobe.
- prog_addr_i  in  2  table entry index.
- prog_div_i  in  5  divider value for the entry.
- prog_dwell_i  in  16  dwell for the entry, in ticks.
- div_o  out  5  divider to the LED counter.
- wren_o  out  1  one-cycle write strobe to the LED counter.
- step_o  out  2  index of the active program step.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- Program table: 4 entries of {div[4:0], dwell[15:0]}.
  - Reset value of every entry is 0.
  - Writes are accepted in any state.
  - A write to the active entry takes effect the next time that entry is loaded.
- FSM states: IDLE, LOAD, DWELL, HOST.
  - IDLE → HOST if host_req_i is high. Else IDLE → LOAD with step = 0 if en_i is high.
  - LOAD: drives div_o = entry[step].div and pulses wren_o, clears the dwell counter and prescaler, then goes to DWELL.
  - DWELL: the prescaler counts 0..TICK_CYC-1, and each wrap increments the dwell counter.
    - When the dwell counter reaches max(entry[step].dwell, 1): step = step+1 (wrapping 3→0), go to LOAD.
    - dwell = 0 is treated as 1.
  - HOST entry (from IDLE, LOAD-complete or DWELL):
    - On the first HOST cycle, div_o = host_div_i, and wren_o and host_ack_o pulse together.
    - While host_req_i stays high, the block remains in HOST with no further writes. host_div_i changes are ignored until re-request.
    - When host_req_i drops, go to LOAD of the same step (dwell restarts) if en_i is high, else to IDLE.
- Priority when events coincide: host_req_i beats dwell expiry. A drop of en_i beats everything except an in-progress HOST.
- If en_i goes low in LOAD or DWELL, the next state is IDLE. No write occurs and div_o holds its value.
- step_o resets to 0 on each IDLE→LOAD entry, not on HOST exit.

## Timing
- All outputs are registered.
- Reset values: div_o=0, wren_o=0, host_ack_o=0, step_o=0, busy_o=0, FSM=IDLE, counters=0.
- Reset asserted mid-operation clears everything immediately, including the program table.
- en_i sampled high in IDLE at edge N: wren_o=1 and div_o valid in the cycle after edge N+1.
- The interval between consecutive program wren_o pulses is exactly max(dwell,1)·TICK_CYC + 1 cycles (the extra cycle is LOAD).
- host_req_i sampled high at edge N in IDLE/DWELL: wren_o and host_ack_o are high in the cycle after edge N+1.
  - If the request lands during LOAD, the override write follows one cycle after the program write.
- wren_o is never high for two consecutive cycles except in the LOAD→HOST case above.

## Structure
- Package led_pkg holds:
  - the state enum (IDLE/LOAD/DWELL/HOST),
  - the typedef for a program entry {div, dwell},
  - DIV_W=5, DWELL_W=16, NSTEP=4.
- Sub-module tick_gen (prescaler with synchronous clear, outputs a one-cycle tick) is instantiated once.
- The LED counter instance stays outside this block; the top-level wrapper connects div_o/wren_o to it.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100, so TICK_CYC=10.
- Reset check: hold rst_n low, then release → all outputs 0, busy_o=0; en_i=0 holds IDLE for 100 cycles with no wren_o.
- Program cycle: entries div={3,7,12,31}, dwell={2,1,3,0}, en_i=1.
  - Required wren_o with div_o sequence 3,7,12,31,3.
  - Required pulse spacing 21, 11, 31, 11 cycles.
  - step_o follows 0,1,2,3,0.
- Override: during step 1 dwell, host_req_i=1 with host_div_i=9 → one wren_o with div_o=9 and host_ack_o pulse two cycles later. Hold the request 50 cycles → no writes. Drop it → div_o=7 rewritten and the full dwell restarts.
- Disable: drop en_i mid-DWELL → IDLE next cycle, no wren_o, div_o holds. Re-enable → restart at step 0.
- Live program write: rewrite entry 2 to div=20 while step 2 is active → current div_o unchanged, next visit to step 2 writes 20.
- Reset mid-DWELL: assert rst_n low for 1 cycle → outputs and table return to 0 asynchronously. With en_i still high after release, step 0 loads div_o=0 and dwell 1 tick.
